// File: rtl/sha1_block_sequencer.sv
// rtl/sha1_block_sequencer.sv - SHA-1 message reader, padder and block sequencer
// Streams 16 big-endian padded words per block to the compression datapath.
module sha1_block_sequencer #(
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_hash,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  input  logic [31:0]       port_A_data_out,
  output logic [31:0]       w_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic              blk_first,
  output logic              blk_last,
  input  logic              core_done,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_FEED,
    S_WAIT_CORE,
    S_DONE
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       size_q;
  logic [31:0]       nb_q;
  logic [31:0]       word_idx;
  logic [1:0]        lat_cnt;

  logic [33:0]       byte_base;
  logic [33:0]       size_ext;
  logic              mem_word;
  logic              final_blk;
  logic [3:0]        j;
  logic [31:0]       word_d;
  logic              load_word;
  logic [32:0]       size_plus8;
  logic [31:0]       nb_d;

  assign port_A_clk = clk;
  assign port_A_we  = 1'b0;

  assign byte_base   = {word_idx, 2'b00};
  assign size_ext    = {2'b00, size_q};
  assign mem_word    = byte_base < size_ext;
  assign j           = word_idx[3:0];
  assign final_blk   = ({4'b0000, word_idx[31:4]} == (nb_q - 32'd1));
  assign port_A_addr = addr_q + ADDR_W'(byte_base);

  assign size_plus8 = {1'b0, message_size} + 33'd8;
  assign nb_d       = 32'(size_plus8 >> 6) + 32'd1;

  // Memory is little-endian; the datapath wants byte 4i in the top lane.
  always_comb begin
    logic [33:0] kb;
    word_d = 32'h0;
    kb     = 34'h0;
    for (int b = 0; b < 4; b++) begin
      kb = byte_base + 34'(b);
      if (kb < size_ext)
        word_d[31-8*b -: 8] = port_A_data_out[8*b +: 8];
      else if (kb == size_ext)
        word_d[31-8*b -: 8] = 8'h80;
    end
    if (final_blk && j == 4'd14)
      word_d = {29'h0, size_q[31:29]};
    else if (final_blk && j == 4'd15)
      word_d = {size_q[28:0], 3'b000};
  end

  always_comb begin
    state_next = state;
    load_word  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_hash) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (!mem_word || lat_cnt == 2'(MEM_LAT)) begin
          load_word  = 1'b1;
          state_next = S_FEED;
        end
      end
      S_FEED: begin
        if (w_ready) state_next = (j == 4'd15) ? S_WAIT_CORE : S_ISSUE;
      end
      S_WAIT_CORE: begin
        if (core_done) state_next = blk_last ? S_DONE : S_ISSUE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      nb_q      <= '0;
      word_idx  <= '0;
      lat_cnt   <= '0;
      w_data    <= '0;
      w_valid   <= 1'b0;
      blk_first <= 1'b0;
      blk_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        S_IDLE, S_DONE: begin
          if (start_hash) begin
            addr_q    <= message_addr[ADDR_W-1:0];
            size_q    <= message_size;
            nb_q      <= nb_d;
            word_idx  <= '0;
            lat_cnt   <= '0;
            blk_first <= 1'b0;
            blk_last  <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (load_word) begin
            w_data    <= word_d;
            w_valid   <= 1'b1;
            blk_first <= (word_idx[31:4] == 28'h0);
            blk_last  <= final_blk;
            lat_cnt   <= '0;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        S_FEED: begin
          if (w_ready) begin
            w_valid  <= 1'b0;
            word_idx <= word_idx + 32'd1;
          end
        end
        S_WAIT_CORE: begin
          // blk_last still reflects the block the datapath just finished.
          if (core_done && blk_last) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_block_sequencer.sv
// tb/tb_sha1_block_sequencer.sv - directed self-checking bench for sha1_block_sequencer
module tb_sha1_block_sequencer;

  logic        clk = 1'b0;
  logic        reset, start_hash, w_ready, core_done;
  logic [31:0] message_addr, message_size, port_A_data_out, w_data;
  logic        port_A_clk, port_A_we, w_valid, blk_first, blk_last, busy, done;
  logic [15:0] port_A_addr;

  sha1_block_sequencer #(.ADDR_W(16), .MEM_LAT(1)) dut (
    .clk(clk), .reset(reset), .start_hash(start_hash),
    .message_addr(message_addr), .message_size(message_size),
    .port_A_clk(port_A_clk), .port_A_addr(port_A_addr), .port_A_we(port_A_we),
    .port_A_data_out(port_A_data_out),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .blk_first(blk_first), .blk_last(blk_last), .core_done(core_done),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:16383];
  always @(posedge clk) port_A_data_out <= mem[port_A_addr[15:2]];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  logic [31:0] got_w [0:63];
  logic        got_f [0:63];
  logic        got_l [0:63];
  logic        seen  [0:63];
  int          n, reads, nf, nl;

  task automatic do_hash(input logic [31:0] base, input logic [31:0] len, input int stall_word);
    int          pend, stall_cnt;
    logic [31:0] held;
    logic [15:0] off;
    bit          fin;
    n = 0; pend = 0; stall_cnt = 0; fin = 0; held = 0;
    for (int i = 0; i < 64; i++) seen[i] = 1'b0;
    @(negedge clk);
    message_addr = base; message_size = len; start_hash = 1'b1; w_ready = 1'b1; core_done = 1'b0;
    @(negedge clk);
    start_hash = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk);
      core_done = 1'b0;
      if (done) fin = 1;
      else begin
        if (busy) begin
          off = port_A_addr - base[15:0];
          if (off < 16'd256 && {16'h0, off} < len) seen[off[7:2]] = 1'b1;
        end
        if (pend > 0) begin
          pend--;
          if (pend == 0) core_done = 1'b1;
        end
        if (n == stall_word && stall_cnt < 5 && (w_valid || stall_cnt > 0)) begin
          if (stall_cnt == 0) held = w_data;
          else begin
            check("hold_data", w_data, held);
            check("hold_valid", {31'h0, w_valid}, 32'd1);
          end
          stall_cnt++;
          w_ready = 1'b0;
        end else begin
          w_ready = 1'b1;
        end
        if (w_valid && w_ready && n < 64) begin
          got_w[n] = w_data; got_f[n] = blk_first; got_l[n] = blk_last;
          n++;
          if (n % 16 == 0) pend = 2;
        end
      end
    end
    check("timeout_done", {31'h0, fin}, 32'd1);
    reads = 0; nf = 0; nl = 0;
    for (int i = 0; i < 64; i++) begin
      if (seen[i]) reads++;
      if (i < n && got_f[i]) nf++;
      if (i < n && got_l[i]) nl++;
    end
  endtask

  initial begin
    reset = 1'b1; start_hash = 1'b0; w_ready = 1'b0; core_done = 1'b0;
    message_addr = 32'h0; message_size = 32'h0;
    for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check("rst_valid", {31'h0, w_valid}, 32'd0);
    check("rst_data", w_data, 32'h0);
    check("rst_addr", {16'h0, port_A_addr}, 32'h0);
    check("rst_we", {31'h0, port_A_we}, 32'd0);
    check("rst_blk", {30'h0, blk_first, blk_last}, 32'd0);
    reset = 1'b0;

    // "abc"
    mem[0] = 32'h00636261;
    do_hash(32'h0, 32'd3, -1);
    check("abc_n", n, 16);
    check("abc_w0", got_w[0], 32'h61626380);
    for (int i = 1; i < 15; i++) check("abc_zero", got_w[i], 32'h0);
    check("abc_w15", got_w[15], 32'h00000018);
    check("abc_first", nf, 16);
    check("abc_last", nl, 16);
    check("abc_done", {30'h0, done, busy}, 32'd2);

    // byte k of the message holds k+1
    for (int w = 0; w < 16; w++)
      mem[w] = {8'(4*w+4), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1)};

    do_hash(32'h0, 32'd56, -1);
    check("l56_n", n, 32);
    check("l56_w0", got_w[0], 32'h01020304);
    check("l56_w13", got_w[13], 32'h35363738);
    check("l56_w14", got_w[14], 32'h80000000);
    check("l56_w15", got_w[15], 32'h0);
    for (int i = 16; i < 31; i++) check("l56_b1zero", got_w[i], 32'h0);
    check("l56_w31", got_w[31], 32'h000001C0);
    check("l56_first", nf, 16);
    check("l56_last", nl, 16);
    check("l56_l15", {31'h0, got_l[15]}, 32'd0);
    check("l56_l16", {31'h0, got_l[16]}, 32'd1);
    check("l56_f16", {31'h0, got_f[16]}, 32'd0);
    check("l56_reads", reads, 14);

    do_hash(32'h0, 32'd0, -1);
    check("l0_n", n, 16);
    check("l0_w0", got_w[0], 32'h80000000);
    check("l0_w1", got_w[1], 32'h0);
    check("l0_w15", got_w[15], 32'h0);
    check("l0_reads", reads, 0);

    do_hash(32'h0, 32'd55, -1);
    check("l55_n", n, 16);
    check("l55_w13", got_w[13], 32'h35363780);
    check("l55_w14", got_w[14], 32'h0);
    check("l55_w15", got_w[15], 32'h000001B8);

    do_hash(32'h0, 32'd64, 5);
    check("l64_n", n, 32);
    check("l64_w4", got_w[4], 32'h11121314);
    check("l64_w5", got_w[5], 32'h15161718);
    check("l64_w6", got_w[6], 32'h191A1B1C);
    check("l64_w14", got_w[14], 32'h393A3B3C);
    check("l64_w15", got_w[15], 32'h3D3E3F40);
    check("l64_w16", got_w[16], 32'h80000000);
    check("l64_w31", got_w[31], 32'h00000200);

    // start while busy is ignored, then reset aborts mid-FEED
    @(negedge clk);
    w_ready = 1'b0; message_addr = 32'h0; message_size = 32'd56; start_hash = 1'b1;
    @(negedge clk);
    start_hash = 1'b0;
    for (int k = 0; k < 20 && !w_valid; k++) @(negedge clk);
    check("ign_valid", {31'h0, w_valid}, 32'd1);
    message_size = 32'd0; start_hash = 1'b1;
    @(negedge clk);
    start_hash = 1'b0;
    check("ign_w0", w_data, 32'h01020304);
    w_ready = 1'b1;
    @(negedge clk);
    w_ready = 1'b0;
    for (int k = 0; k < 20 && !w_valid; k++) @(negedge clk);
    check("ign_w1", w_data, 32'h05060708);
    check("ign_busy", {31'h0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_valid", {31'h0, w_valid}, 32'd0);
    check("abort_addr", {16'h0, port_A_addr}, 32'h0);
    check("abort_done", {31'h0, done}, 32'd0);
    reset = 1'b0;

    // address wrap at the top of the 16-bit space
    mem[16383] = 32'h44332211;
    mem[0]     = 32'h88776655;
    do_hash(32'h0000FFFC, 32'd8, -1);
    check("wrap_n", n, 16);
    check("wrap_w0", got_w[0], 32'h11223344);
    check("wrap_w1", got_w[1], 32'h55667788);
    check("wrap_w2", got_w[2], 32'h80000000);
    check("wrap_w15", got_w[15], 32'h00000040);
    check("wrap_reads", reads, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
